// File: rtl/aes_pkg.sv
// AES key-schedule constants: S-box, round constants, key-size encodings and
// per-size Nk/Nr/last-word figures, plus the expander FSM state type.
package aes_pkg;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_INV = 2'b11;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Rcon[1..10]; index 0 and 11..15 never occur during expansion.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            MODE_128: return NK_128;
            MODE_192: return NK_192;
            MODE_256: return NK_256;
            default:  return NK_128;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_128: return NR_128;
            MODE_192: return NR_192;
            MODE_256: return NR_256;
            default:  return NR_128;
        endcase
    endfunction

    // Index of the final schedule word, 4*(Nr+1)-1.
    function automatic logic [5:0] last_of(input logic [1:0] mode);
        case (mode)
            MODE_128: return 6'd43;
            MODE_192: return 6'd51;
            MODE_256: return 6'd59;
            default:  return 6'd43;
        endcase
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box substitutions on one 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/key_expansion_iter.sv
// Iterative AES key expansion (128/192/256), one schedule word per cycle.
// Optional feature macro KEY_EXPANSION_DEC_EN adds the Dec input, which
// selects round keys in reverse (decryption) order.
module key_expansion_iter
    import aes_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [1:0]   Mode,
    input  logic [255:0] KeyIn,
    input  logic [3:0]   SelKey,
`ifdef KEY_EXPANSION_DEC_EN
    input  logic         Dec,
`endif
    output logic [127:0] Key,
    output logic         Ry,
    output logic         Busy,
    output logic         Err
);

    state_t       state_q, state_d;
    logic [1:0]   mode_q, mode_d;
    logic [3:0]   nk_q, nk_d;
    logic [3:0]   nr_q, nr_d;
    logic [5:0]   last_q, last_d;
    logic [5:0]   i_q, i_d;        // index of word being produced
    logic [2:0]   imod_q, imod_d;  // i mod Nk
    logic [3:0]   idiv_q, idiv_d;  // i / Nk
    logic         ry_q, ry_d;
    logic         busy_q, busy_d;
    logic         err_q, err_d;
    logic [127:0] key_q, key_d;

    logic [31:0]  w_q [0:59];

    logic         can_start_s;
    logic [3:0]   load_nk_s;
    logic [5:0]   prev_idx_s;
    logic [5:0]   back_idx_s;
    logic [31:0]  prev_s;
    logic [31:0]  sub_in_s;
    logic [31:0]  sub_out_s;
    logic [31:0]  temp_s;
    logic [31:0]  new_word_s;
    logic [3:0]   sel_eff_s;
    logic         key_ok_s;
    logic [5:0]   kbase_s;

    aes_subword u_subword (
        .word_i (sub_in_s),
        .word_o (sub_out_s)
    );

    // Schedule word datapath: w[i] = w[i-Nk] ^ t, sharing the single SubWord.
    always_comb begin
        load_nk_s  = nk_of(mode_q);
        prev_idx_s = 6'd0;
        back_idx_s = 6'd0;
        if (state_q == ST_EXPAND) begin
            prev_idx_s = i_q - 6'd1;
            back_idx_s = i_q - {2'b00, nk_q};
        end else begin
            prev_idx_s = 6'd0;
            back_idx_s = 6'd0;
        end
        prev_s = w_q[prev_idx_s];
        if (imod_q == 3'd0) begin
            sub_in_s = {prev_s[23:0], prev_s[31:24]};
            temp_s   = sub_out_s ^ {rcon_of(idiv_q), 24'h000000};
        end else if ((nk_q == NK_256) && (imod_q == 3'd4)) begin
            sub_in_s = prev_s;
            temp_s   = sub_out_s;
        end else begin
            sub_in_s = prev_s;
            temp_s   = prev_s;
        end
        new_word_s = w_q[back_idx_s] ^ temp_s;
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        nk_d        = nk_q;
        nr_d        = nr_q;
        last_d      = last_q;
        i_d         = i_q;
        imod_d      = imod_q;
        idiv_d      = idiv_q;
        ry_d        = ry_q;
        busy_d      = busy_q;
        err_d       = 1'b0;
        can_start_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                can_start_s = Start;
                if (Start && (Mode != MODE_INV)) begin
                    state_d = ST_LOAD;
                    mode_d  = Mode;
                    ry_d    = 1'b0;
                    busy_d  = 1'b1;
                end else if (Start) begin
                    err_d = 1'b1;
                end else if (state_q == ST_DONE) begin
                    ry_d = 1'b1;
                end else begin
                    ry_d = ry_q;
                end
            end
            ST_LOAD: begin
                nk_d    = load_nk_s;
                nr_d    = nr_of(mode_q);
                last_d  = last_of(mode_q);
                i_d     = {2'b00, load_nk_s};
                imod_d  = 3'd0;
                idiv_d  = 4'd1;
                state_d = ST_EXPAND;
            end
            ST_EXPAND: begin
                if (i_q == last_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    i_d     = 6'd0;
                    imod_d  = 3'd0;
                    idiv_d  = 4'd0;
                end else if ({1'b0, imod_q} == (nk_q - 4'd1)) begin
                    i_d    = i_q + 6'd1;
                    imod_d = 3'd0;
                    idiv_d = idiv_q + 4'd1;
                end else begin
                    i_d    = i_q + 6'd1;
                    imod_d = imod_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ry_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

`ifdef KEY_EXPANSION_DEC_EN
        sel_eff_s = Dec ? (nr_q - SelKey) : SelKey;
`else
        sel_eff_s = SelKey;
`endif
        // Gate with next Ry so Key and Ry always change on the same edge.
        key_ok_s = ry_d && (SelKey <= nr_q);
        if (key_ok_s) begin
            kbase_s = {sel_eff_s, 2'b00};
            key_d   = {w_q[kbase_s], w_q[kbase_s + 6'd1],
                       w_q[kbase_s + 6'd2], w_q[kbase_s + 6'd3]};
        end else begin
            kbase_s = 6'd0;
            key_d   = 128'd0;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_128;
            nk_q    <= 4'd0;
            nr_q    <= 4'd0;
            last_q  <= 6'd0;
            i_q     <= 6'd0;
            imod_q  <= 3'd0;
            idiv_q  <= 4'd0;
            ry_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            key_q   <= 128'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            nk_q    <= nk_d;
            nr_q    <= nr_d;
            last_q  <= last_d;
            i_q     <= i_d;
            imod_q  <= imod_d;
            idiv_q  <= idiv_d;
            ry_q    <= ry_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            key_q   <= key_d;
        end
    end

    // Word storage: Nk key words in LOAD, one expanded word per EXPAND cycle.
    always_ff @(posedge Clk) begin
        if (state_q == ST_LOAD) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(load_nk_s)) begin
                    w_q[k] <= KeyIn[255 - 32*k -: 32];
                end
            end
        end else if (state_q == ST_EXPAND) begin
            w_q[i_q] <= new_word_s;
        end
    end

    assign Key  = key_q;
    assign Ry   = ry_q;
    assign Busy = busy_q;
    assign Err  = err_q;

endmodule

// File: tb/tb_key_expansion_iter.sv
// Directed self-checking bench for key_expansion_iter using FIPS-197 vectors.
module tb_key_expansion_iter;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         Start = 1'b0;
    logic [1:0]   Mode = 2'b00;
    logic [255:0] KeyIn = 256'd0;
    logic [3:0]   SelKey = 4'd0;
`ifdef KEY_EXPANSION_DEC_EN
    logic         Dec = 1'b0;
`endif
    logic [127:0] Key;
    logic         Ry;
    logic         Busy;
    logic         Err;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'd0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_expansion_iter dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .Mode   (Mode),
        .KeyIn  (KeyIn),
        .SelKey (SelKey),
`ifdef KEY_EXPANSION_DEC_EN
        .Dec    (Dec),
`endif
        .Key    (Key),
        .Ry     (Ry),
        .Busy   (Busy),
        .Err    (Err)
    );

    always #5 Clk = ~Clk;

    // Issue Start; count edges after the sampling edge until Ry rises (-1 on timeout).
    // A non-zero pulse_at re-pulses Start (with Mode=01) at that cycle.
    task automatic do_expand(input logic [1:0] m, input logic [255:0] k,
                             input int pulse_at, output int lat);
        Mode = m; KeyIn = k; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n == pulse_at) begin
                Start = 1'b1; Mode = 2'b01;
            end
            @(posedge Clk); #1;
            if (Start) begin
                Start = 1'b0; Mode = m;
            end
            if (Ry) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic read_key(input logic [3:0] sel, output logic [127:0] k);
        SelKey = sel;
        @(posedge Clk); #1;
        k = Key;
    endtask

    task automatic test_reset;
        #2 Rst = 1'b0;
        #1;
        checks++;
        if ({Ry, Busy, Err} !== 3'b000 || Key !== 128'd0) begin
            errors++;
            $display("FAIL reset_outputs: Ry=%b Busy=%b Err=%b Key=%h, required all zero", Ry, Busy, Err, Key);
        end
        @(posedge Clk); #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if ({Ry, Busy, Err} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: Ry=%b Busy=%b Err=%b, required 000", Ry, Busy, Err);
        end
    endtask

    task automatic test_invalid_mode;
        Mode = 2'b11; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; Mode = 2'b00;
        checks++;
        if ({Err, Busy, Ry} !== 3'b100) begin
            errors++;
            $display("FAIL err_pulse: Err/Busy/Ry=%b, required 100", {Err, Busy, Ry});
        end
        @(posedge Clk); #1;
        checks++;
        if ({Err, Busy, Ry} !== 3'b000) begin
            errors++;
            $display("FAIL err_clear: Err/Busy/Ry=%b, required 000", {Err, Busy, Ry});
        end
    endtask

    task automatic test_aes128;
        int lat;
        logic [127:0] k;
        do_expand(2'b00, K128, 10, lat);
        checks++;
        if (lat != 42) begin
            errors++;
            $display("FAIL lat128: got %0d, required 42", lat);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_done128: got %b, required 0", Busy);
        end
        read_key(4'd0, k);
        checks++;
        if (k !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            errors++;
            $display("FAIL k128_0: got %h, required 2b7e151628aed2a6abf7158809cf4f3c", k);
        end
        read_key(4'd1, k);
        checks++;
        if (k !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL k128_1: got %h, required a0fafe1788542cb123a339392a6c7605", k);
        end
        read_key(4'd10, k);
        checks++;
        if (k !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL k128_10: got %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", k);
        end
        read_key(4'd11, k);
        checks++;
        if (k !== 128'd0) begin
            errors++;
            $display("FAIL k128_11_oor: got %h, required 0", k);
        end
    endtask

    task automatic test_done_invalid;
        Mode = 2'b11; Start = 1'b1; SelKey = 4'd10;
        @(posedge Clk); #1;
        Start = 1'b0; Mode = 2'b00;
        checks++;
        if ({Err, Busy, Ry} !== 3'b101 || Key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL done_invalid: Err/Busy/Ry=%b Key=%h, required 101 and key10", {Err, Busy, Ry}, Key);
        end
    endtask

    task automatic test_aes192;
        int lat;
        logic [127:0] k;
        do_expand(2'b01, K192, 0, lat);
        checks++;
        if (lat != 48) begin
            errors++;
            $display("FAIL lat192: got %0d, required 48", lat);
        end
        read_key(4'd0, k);
        checks++;
        if (k !== 128'h8e73b0f7da0e6452c810f32b809079e5) begin
            errors++;
            $display("FAIL k192_0: got %h, required 8e73b0f7da0e6452c810f32b809079e5", k);
        end
        read_key(4'd12, k);
        checks++;
        if (k !== 128'he98ba06f448c773c8ecc720401002202) begin
            errors++;
            $display("FAIL k192_12: got %h, required e98ba06f448c773c8ecc720401002202", k);
        end
        read_key(4'd13, k);
        checks++;
        if (k !== 128'd0) begin
            errors++;
            $display("FAIL k192_13_oor: got %h, required 0", k);
        end
    endtask

    task automatic test_aes256;
        int lat;
        logic [127:0] k;
        do_expand(2'b10, K256, 0, lat);
        checks++;
        if (lat != 54) begin
            errors++;
            $display("FAIL lat256: got %0d, required 54", lat);
        end
        read_key(4'd1, k);
        checks++;
        if (k !== 128'h1f352c073b6108d72d9810a30914dff4) begin
            errors++;
            $display("FAIL k256_1: got %h, required 1f352c073b6108d72d9810a30914dff4", k);
        end
        read_key(4'd14, k);
        checks++;
        if (k !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            errors++;
            $display("FAIL k256_14: got %h, required fe4890d1e6188d0b046df344706c631e", k);
        end
        read_key(4'd15, k);
        checks++;
        if (k !== 128'd0) begin
            errors++;
            $display("FAIL k256_15_oor: got %h, required 0", k);
        end
    endtask

    task automatic test_abort;
        int lat;
        logic [127:0] k;
        SelKey = 4'd1;
        Mode = 2'b00; KeyIn = K128; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        checks++;
        if (Ry !== 1'b0 || Key !== 128'd0) begin
            errors++;
            $display("FAIL ry_fall_on_start: Ry=%b Key=%h, required 0 and 0", Ry, Key);
        end
        repeat (21) begin
            @(posedge Clk); #1;
        end
        checks++;
        if ({Busy, Ry} !== 2'b10) begin
            errors++;
            $display("FAIL mid_expand: Busy/Ry=%b, required 10", {Busy, Ry});
        end
        #2 Rst = 1'b0;
        #1;
        checks++;
        if ({Ry, Busy, Err} !== 3'b000 || Key !== 128'd0) begin
            errors++;
            $display("FAIL abort_reset: Ry=%b Busy=%b Err=%b Key=%h, required zeros", Ry, Busy, Err, Key);
        end
        @(posedge Clk); #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        do_expand(2'b00, K128, 0, lat);
        checks++;
        if (lat != 42) begin
            errors++;
            $display("FAIL lat128_after_abort: got %0d, required 42", lat);
        end
        read_key(4'd1, k);
        checks++;
        if (k !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL abort_k1: got %h, required a0fafe1788542cb123a339392a6c7605", k);
        end
        read_key(4'd10, k);
        checks++;
        if (k !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL abort_k10: got %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", k);
        end
    endtask

`ifdef KEY_EXPANSION_DEC_EN
    task automatic test_dec;
        logic [127:0] k;
        Dec = 1'b1;
        read_key(4'd0, k);
        checks++;
        if (k !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL dec_k0: got %h, required d014f9a8c9ee2589e13f0cc8b6630ca6", k);
        end
        read_key(4'd10, k);
        checks++;
        if (k !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            errors++;
            $display("FAIL dec_k10: got %h, required 2b7e151628aed2a6abf7158809cf4f3c", k);
        end
        Dec = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_invalid_mode();
        test_aes128();
        test_done_invalid();
        test_aes192();
        test_aes256();
        test_abort();
`ifdef KEY_EXPANSION_DEC_EN
        test_dec();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
